// File: rtl/dds_sample_gen.sv
// Phase-accumulator waveform generator (saw/square/triangle/constant) driven by an external sample strobe.
// Latency: Sample/SampleValid/Wrap appear one cycle after the accepted Enable.
// Backpressure: none; every accepted Enable yields exactly one SampleValid, and Mode changes resynchronise the phase.
module dds_sample_gen #(
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 8
) (
    input  logic               Fg_clk,
    input  logic               Resetn,
    input  logic               Ready,
    input  logic               Enable,
    input  logic [2:0]         Mode,
    input  logic [PHASE_W-1:0] TuneWord,
    input  logic [1:0]         WaveSel,
    output logic [OUT_W-1:0]   Sample,
    output logic               SampleValid,
    output logic               Wrap,
    output logic               Running,
    output logic [15:0]        SampleCount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t             state;
    logic [PHASE_W-1:0] phase;
    logic [2:0]         mode_q;

    logic [PHASE_W:0]   sum;
    logic [OUT_W-1:0]   step_smp;
    logic [OUT_W-1:0]   zero_smp;
    logic               mode_chg;
    logic [15:0]        count_inc;

    // Map a phase value onto the selected waveform.
    function automatic logic [OUT_W-1:0] wave_fn(input logic [PHASE_W-1:0] p,
                                                 input logic [1:0]         sel);
        logic [OUT_W-1:0] t;
        logic [OUT_W-1:0] r;
        t = p[PHASE_W-2 -: OUT_W];
        case (sel)
            2'd0:    r = p[PHASE_W-1 -: OUT_W];
            2'd1:    r = {OUT_W{p[PHASE_W-1]}};
            2'd2:    r = p[PHASE_W-1] ? ~t : t;
            default: r = {1'b1, {(OUT_W-1){1'b0}}};
        endcase
        return r;
    endfunction

    // Next-phase candidate, waveform lookups and saturating count.
    always_comb begin
        sum       = {1'b0, phase} + {1'b0, TuneWord};
        step_smp  = wave_fn(sum[PHASE_W-1:0], WaveSel);
        zero_smp  = wave_fn('0, WaveSel);
        mode_chg  = (Mode != mode_q);
        count_inc = (SampleCount == 16'hFFFF) ? SampleCount : SampleCount + 16'd1;
    end

    assign Running = (state != IDLE);

    // Control FSM with phase accumulator and registered sample outputs.
    always_ff @(posedge Fg_clk or negedge Resetn) begin
        if (!Resetn) begin
            state       <= IDLE;
            phase       <= '0;
            mode_q      <= '0;
            Sample      <= '0;
            SampleValid <= 1'b0;
            Wrap        <= 1'b0;
            SampleCount <= '0;
        end else begin
            mode_q      <= Mode;
            SampleValid <= 1'b0;
            Wrap        <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (Ready) begin
                        state       <= RUN;
                        SampleCount <= '0;
                    end
                end
                RUN: begin
                    if (Ready) begin
                        phase       <= '0;
                        SampleCount <= '0;
                    end else if (mode_chg) begin
                        // Coincident Enable is dropped; the next one restarts from phase 0.
                        state <= RESYNC;
                    end else if (Enable) begin
                        phase       <= sum[PHASE_W-1:0];
                        Sample      <= step_smp;
                        SampleValid <= 1'b1;
                        Wrap        <= sum[PHASE_W];
                        SampleCount <= count_inc;
                    end
                end
                RESYNC: begin
                    if (Ready) begin
                        state       <= RUN;
                        phase       <= '0;
                        SampleCount <= '0;
                    end else if (mode_chg) begin
                        // Mode still moving: keep waiting, ignore Enable.
                        state <= RESYNC;
                    end else if (Enable) begin
                        state       <= RUN;
                        phase       <= '0;
                        Sample      <= zero_smp;
                        SampleValid <= 1'b1;
                        SampleCount <= count_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    phase <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sample_gen.sv
module tb_dds_sample_gen;

    logic        Fg_clk;
    logic        Resetn;
    logic        Ready;
    logic        Enable;
    logic [2:0]  Mode;
    logic [15:0] TuneWord;
    logic [1:0]  WaveSel;
    logic [7:0]  Sample;
    logic        SampleValid;
    logic        Wrap;
    logic        Running;
    logic [15:0] SampleCount;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] smp;
        logic       wrap;
        int         cyc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        rdy;
        logic        en;
        logic [2:0]  mode;
        logic [15:0] tw;
        logic [1:0]  ws;
        logic        vld;
        logic [7:0]  smp;
        logic        wrap;
        logic        run;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl[28];

    logic [7:0] last_smp;

    dds_sample_gen #(.PHASE_W(16), .OUT_W(8)) dut (
        .Fg_clk      (Fg_clk),
        .Resetn      (Resetn),
        .Ready       (Ready),
        .Enable      (Enable),
        .Mode        (Mode),
        .TuneWord    (TuneWord),
        .WaveSel     (WaveSel),
        .Sample      (Sample),
        .SampleValid (SampleValid),
        .Wrap        (Wrap),
        .Running     (Running),
        .SampleCount (SampleCount)
    );

    initial begin
        Fg_clk = 1'b0;
        forever #5 Fg_clk = ~Fg_clk;
    end

    always @(posedge Fg_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every SampleValid must match the oldest expectation.
    always @(posedge Fg_clk) begin
        sb_t e;
        #1;
        if (Resetn) begin
            chk("wrap_without_valid", {31'd0, Wrap & ~SampleValid}, 32'd0);
            if (SampleValid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got Sample 0x%0h with no expectation (cycle %0d)", Sample, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("sample", {24'd0, Sample}, {24'd0, e.smp});
                    chk("wrap", {31'd0, Wrap}, {31'd0, e.wrap});
                    chk("latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // One clock of stimulus; expected sample queued at drive time, status checked after the edge.
    task automatic step(input logic rdy, input logic en, input logic [2:0] mode,
                        input logic [15:0] tw, input logic [1:0] ws,
                        input logic vld, input logic [7:0] smp, input logic wrap,
                        input logic run, input logic [15:0] cnt);
        sb_t e;
        @(negedge Fg_clk);
        Ready    = rdy;
        Enable   = en;
        Mode     = mode;
        TuneWord = tw;
        WaveSel  = ws;
        if (vld) begin
            e.smp  = smp;
            e.wrap = wrap;
            e.cyc  = cyc + 1;
            sb.push_back(e);
            last_smp = smp;
        end
        @(posedge Fg_clk);
        #1;
        chk("running", {31'd0, Running}, {31'd0, run});
        chk("sample_count", {16'd0, SampleCount}, {16'd0, cnt});
        chk("sample_hold", {24'd0, Sample}, {24'd0, last_smp});
    endtask

    initial begin
        logic [16:0] mph;
        logic [15:0] ecnt;

        //          rdy  en   mode  tw        ws    vld  smp    wrap run  cnt
        tbl[0]  = '{1'b0,1'b1,3'd0,16'h1000,2'd0,1'b0,8'h00,1'b0,1'b0,16'd0};
        tbl[1]  = '{1'b1,1'b0,3'd0,16'h0000,2'd0,1'b0,8'h00,1'b0,1'b1,16'd0};
        tbl[2]  = '{1'b0,1'b1,3'd0,16'h1000,2'd0,1'b1,8'h10,1'b0,1'b1,16'd1};
        tbl[3]  = '{1'b0,1'b1,3'd0,16'h1000,2'd0,1'b1,8'h20,1'b0,1'b1,16'd2};
        tbl[4]  = '{1'b0,1'b1,3'd0,16'h1000,2'd0,1'b1,8'h30,1'b0,1'b1,16'd3};
        tbl[5]  = '{1'b0,1'b0,3'd0,16'h1000,2'd0,1'b0,8'h00,1'b0,1'b1,16'd3};
        tbl[6]  = '{1'b1,1'b0,3'd0,16'h0000,2'd0,1'b0,8'h00,1'b0,1'b1,16'd0};
        tbl[7]  = '{1'b0,1'b1,3'd0,16'h8000,2'd0,1'b1,8'h80,1'b0,1'b1,16'd1};
        tbl[8]  = '{1'b0,1'b1,3'd0,16'h8000,2'd0,1'b1,8'h00,1'b1,1'b1,16'd2};
        tbl[9]  = '{1'b0,1'b1,3'd0,16'h8000,2'd0,1'b1,8'h80,1'b0,1'b1,16'd3};
        tbl[10] = '{1'b0,1'b1,3'd0,16'h8000,2'd0,1'b1,8'h00,1'b1,1'b1,16'd4};
        tbl[11] = '{1'b1,1'b0,3'd0,16'h0000,2'd0,1'b0,8'h00,1'b0,1'b1,16'd0};
        tbl[12] = '{1'b0,1'b1,3'd0,16'h4000,2'd2,1'b1,8'h80,1'b0,1'b1,16'd1};
        tbl[13] = '{1'b0,1'b1,3'd0,16'h4000,2'd2,1'b1,8'hFF,1'b0,1'b1,16'd2};
        tbl[14] = '{1'b0,1'b1,3'd0,16'h4000,2'd2,1'b1,8'h7F,1'b0,1'b1,16'd3};
        tbl[15] = '{1'b0,1'b1,3'd0,16'h0000,2'd1,1'b1,8'hFF,1'b0,1'b1,16'd4};
        tbl[16] = '{1'b0,1'b1,3'd0,16'h0000,2'd3,1'b1,8'h80,1'b0,1'b1,16'd5};
        tbl[17] = '{1'b0,1'b1,3'd0,16'h5000,2'd0,1'b1,8'h10,1'b1,1'b1,16'd6};
        tbl[18] = '{1'b0,1'b1,3'd1,16'h1000,2'd0,1'b0,8'h00,1'b0,1'b1,16'd6};
        tbl[19] = '{1'b0,1'b1,3'd2,16'h1000,2'd0,1'b0,8'h00,1'b0,1'b1,16'd6};
        tbl[20] = '{1'b0,1'b1,3'd2,16'h1000,2'd3,1'b1,8'h80,1'b0,1'b1,16'd7};
        tbl[21] = '{1'b0,1'b1,3'd2,16'h1000,2'd0,1'b1,8'h10,1'b0,1'b1,16'd8};
        tbl[22] = '{1'b1,1'b1,3'd2,16'h1000,2'd0,1'b0,8'h00,1'b0,1'b1,16'd0};
        tbl[23] = '{1'b0,1'b1,3'd2,16'h1000,2'd0,1'b1,8'h10,1'b0,1'b1,16'd1};
        tbl[24] = '{1'b0,1'b0,3'd3,16'h1000,2'd0,1'b0,8'h00,1'b0,1'b1,16'd1};
        tbl[25] = '{1'b1,1'b0,3'd3,16'h1000,2'd0,1'b0,8'h00,1'b0,1'b1,16'd0};
        tbl[26] = '{1'b0,1'b1,3'd3,16'h1000,2'd0,1'b1,8'h10,1'b0,1'b1,16'd1};
        tbl[27] = '{1'b0,1'b1,3'd3,16'h1000,2'd2,1'b1,8'h40,1'b0,1'b1,16'd2};

        Resetn   = 1'b0;
        Ready    = 1'b0;
        Enable   = 1'b0;
        Mode     = 3'd0;
        TuneWord = 16'h0000;
        WaveSel  = 2'd0;
        last_smp = 8'h00;

        // Reset state.
        repeat (2) @(posedge Fg_clk);
        #1;
        chk("rst_sample", {24'd0, Sample}, 32'd0);
        chk("rst_valid", {31'd0, SampleValid}, 32'd0);
        chk("rst_wrap", {31'd0, Wrap}, 32'd0);
        chk("rst_running", {31'd0, Running}, 32'd0);
        chk("rst_count", {16'd0, SampleCount}, 32'd0);
        @(negedge Fg_clk);
        Resetn = 1'b1;

        // Table-driven main function.
        for (int i = 0; i < 28; i++)
            step(tbl[i].rdy, tbl[i].en, tbl[i].mode, tbl[i].tw, tbl[i].ws,
                 tbl[i].vld, tbl[i].smp, tbl[i].wrap, tbl[i].run, tbl[i].cnt);

        // Saturation of SampleCount with a small phase model (TuneWord=1, saw).
        step(1'b1, 1'b0, 3'd3, 16'h0000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0);
        mph = 17'd0;
        for (int n = 1; n <= 65540; n++) begin
            mph  = {1'b0, mph[15:0]} + 17'd1;
            ecnt = (n > 65535) ? 16'hFFFF : n[15:0];
            step(1'b0, 1'b1, 3'd3, 16'h0001, 2'd0, 1'b1, mph[15:8], mph[16], 1'b1, ecnt);
        end

        // Reset mid-run with a pending Enable, then Enable without Ready.
        @(negedge Fg_clk);
        Enable   = 1'b1;
        TuneWord = 16'h1000;
        #2;
        Resetn = 1'b0;
        #1;
        chk("async_rst_sample", {24'd0, Sample}, 32'd0);
        chk("async_rst_running", {31'd0, Running}, 32'd0);
        chk("async_rst_count", {16'd0, SampleCount}, 32'd0);
        chk("async_rst_valid", {31'd0, SampleValid}, 32'd0);
        sb.delete();
        last_smp = 8'h00;
        @(posedge Fg_clk);
        #1;
        chk("rst_hold_valid", {31'd0, SampleValid}, 32'd0);
        @(negedge Fg_clk);
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 3'd0, 16'h1000, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0);
        chk("post_rst_wrap", {31'd0, Wrap}, 32'd0);

        repeat (2) @(posedge Fg_clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_sample_gen.md
DDS_SAMPLE_GEN -- requirements
Module: dds_sample_gen

Interface
REQ-001 Parameter PHASE_W, default 16, phase accumulator and TuneWord width; SHALL be at least OUT_W+2.
REQ-002 Parameter OUT_W, default 8, Sample width.
REQ-003 Fg_clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Resetn  input  1  reset, asynchronous, active-low.
REQ-005 Ready  input  1  one-cycle start/restart pulse from the sampling controller.
REQ-006 Enable  input  1  sample strobe from the sampling controller; one step per high cycle.
REQ-007 Mode  input  3  rate mode from the sampling controller; used only for change detection.
REQ-008 TuneWord  input  PHASE_W  phase increment, sampled on each accepted Enable.
REQ-009 WaveSel  input  2  waveform select: 0 saw, 1 square, 2 triangle, 3 mid-level constant.
REQ-010 Sample  output  OUT_W  registered waveform sample.
REQ-011 SampleValid  output  1  one-cycle pulse; Sample updated in the same cycle.
REQ-012 Wrap  output  1  one-cycle pulse; phase addition overflowed 2^PHASE_W.
REQ-013 Running  output  1  high while state is RUN or RESYNC.
REQ-014 SampleCount  output  16  count of SampleValid pulses since the last start, saturating.

Function
REQ-015 States: IDLE, RUN, RESYNC; internal phase register of PHASE_W bits; ModeQ register of 3 bits, tracking Mode every cycle.
REQ-016 IDLE: phase held at 0; Enable ignored; Ready=1 -> RUN next cycle, phase=0, SampleCount=0.
REQ-017 RUN, Ready=1: phase<=0, SampleCount<=0, stay RUN, no SampleValid; takes priority over Enable and Mode change in the same cycle.
REQ-018 RUN, Mode!=ModeQ (and Ready=0): -> RESYNC; a coincident Enable is ignored (no phase step, no SampleValid).
REQ-019 RUN, Enable=1 (and no Ready, no Mode change): {carry,phase}<=phase+TuneWord; Sample<=f(new phase); SampleValid=1 and Wrap=carry on the next cycle (latency 1 from Enable).
REQ-020 RESYNC: waits for Enable; on Enable phase<=0, Sample<=f(0), SampleValid=1, Wrap=0, -> RUN; Ready in RESYNC behaves as REQ-017 and -> RUN.
REQ-021 Further Mode changes while in RESYNC SHALL keep the state in RESYNC.
REQ-022 f(p), saw: p[PHASE_W-1 -: OUT_W].
REQ-023 f(p), square: all ones if p[PHASE_W-1]=1, else all zeros.
REQ-024 f(p), triangle: t=p[PHASE_W-2 -: OUT_W]; output ~t if p[PHASE_W-1]=1, else t.
REQ-025 f(p), constant: MSB 1, remaining bits 0 (0x80 at OUT_W=8).
REQ-026 WaveSel is sampled combinationally at the update cycle; a change takes effect at the next SampleValid only, and Sample SHALL hold between valid pulses.
REQ-027 TuneWord=0: phase constant, SampleValid still pulses per Enable; Wrap never asserts.
REQ-028 SampleCount increments by 1 with each SampleValid; SHALL hold at 0xFFFF without wrapping.
REQ-029 Running SHALL be 0 only in IDLE.

Reset
REQ-030 Resetn=0 SHALL force, asynchronously: state IDLE, phase 0, ModeQ 0, Sample 0, SampleValid 0, Wrap 0, Running 0, SampleCount 0.
REQ-031 Reset mid-operation SHALL abandon any pending step; after release the block SHALL remain in IDLE until Ready.
REQ-032 Once reset is released, Enable in IDLE SHALL produce no SampleValid.

Verification
REQ-033 Start + saw: Ready pulse, WaveSel=0, TuneWord=0x1000, three Enables -> Sample 0x10, 0x20, 0x30, each one cycle after its Enable; SampleCount=3.
REQ-034 Wrap: TuneWord=0x8000, four Enables -> Wrap high on 2nd and 4th valid; saw Samples 0x80, 0x00, 0x80, 0x00.
REQ-035 Triangle/square: phase stepped to 0xC000 (TuneWord=0x4000, three Enables) -> triangle Sample=0x7F; square Sample=0xFF.
REQ-036 Mode change with coincident Enable -> no SampleValid; next Enable -> Sample=f(0), SampleValid=1, state RUN.
REQ-037 Ready and Enable in the same RUN cycle -> phase 0, no SampleValid, SampleCount=0.
REQ-038 Resetn low mid-run, then Enable pulses with no Ready -> all outputs 0, Running=0, no SampleValid.
